mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, byte-strobed memory between the instruction-fetch requester (I) and the load/store requester (D).
- Sits between the CPU core and the simulation/system memory.
- Arbitrates requests, sequences each memory access with a valid/ready handshake, detects misalignment and memory timeouts, and returns registered responses to the owning requester.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive D grants while IReq is pending before I is forced to win; 1..15.
- TIMEOUT, 16: cycles in ACCESS without iwMemReady before the access is aborted; 0 disables the timeout.

Ports:
- iwClk  in  1  clock; all state updates on the rising edge
- iwnRst  in  1  reset, asynchronous, active-low
- iwIReq  in  1  fetch request; held until owIGnt
- iwIAddr  in  32  fetch word address
- owIGnt  out  1  fetch accepted (combinational, IDLE only)
- owIRvalid  out  1  fetch response pulse
- owIRdata  out  32  fetch data
- owIErr  out  1  fetch error, qualified by owIRvalid
- iwDReq  in  1  data request; held until owDGnt
- iwDAddr  in  32  data word address
- iwDWstrb  in  4  byte strobes; 0 means read
- iwDWdata  in  32  write data
- owDGnt  out  1  data accepted
- owDRvalid  out  1  data response pulse
- owDRdata  out  32  read data (0 for writes)
- owDErr  out  1  data error
- owMemValid  out  1  memory access active
- owMemAddr  out  32  memory address
- owMemWdata  out  32  memory write data
- owMemWstrb  out  4  memory strobes; 0 means read
- iwMemReady  in  1  memory completes the access in this cycle
- iwMemRdata  in  32  read data, valid when iwMemReady

Behaviour:
- Reset state:
  - While iwnRst is low: state IDLE, starve counter 0, timeout counter 0.
  - All outputs 0, including owMemValid, which deasserts immediately and asynchronously.
  - An in-flight access is dropped with no response.
- States: IDLE, ACCESS.
- IDLE, winner selection:
  - If only one request is pending, that requester wins.
  - If both are pending, D wins unless starve counter == STARVE_LIMIT, in which case I wins.
- IDLE, grant:
  - The winner's Gnt is high combinationally in the same cycle. Exactly one Gnt at most.
  - The address, wdata, wstrb and owner are registered.
- IDLE, misaligned request (Addr[1:0] != 0):
  - The request is still granted; no memory cycle is issued and the state stays IDLE.
  - The next cycle carries Rvalid=1, Err=1, Rdata=0.
- IDLE, aligned request: go to ACCESS.
- ACCESS, memory side:
  - owMemValid=1, with owMemAddr, owMemWdata and owMemWstrb stable until the handshake.
  - The handshake is the cycle where owMemValid && iwMemReady.
- ACCESS, on handshake:
  - iwMemRdata is captured (a write returns Rdata=0) and the state returns to IDLE.
  - The owner sees Rvalid=1, Err=0 in the following cycle.
- ACCESS, timeout: if TIMEOUT != 0 and the timeout counter reaches TIMEOUT without ready, the access is aborted. The state returns to IDLE, owMemValid drops, and the owner gets Rvalid=1, Err=1, Rdata=0 the next cycle.
- Latency and throughput:
  - Request in cycle 0 → grant in cycle 0, owMemValid in cycle 1.
  - With ready in cycle 1 → Rvalid in cycle 2.
  - A new grant is possible in cycle 2, so peak throughput is one access per 2 cycles.
- Output pulses: Rvalid/Err are 1-cycle pulses. Rdata holds its value until the next response to the same requester.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each D grant while iwIReq=1.
  - Clears on an I grant, or on a D grant with iwIReq=0.
- Timeout counter: clears on entering ACCESS and increments each ACCESS cycle without ready.
- Response vs grant: a response pulse and a new grant in the same cycle are legal and independent.
- Request removal: a requester that drops Req before Gnt is simply not served; there is no protocol error.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding (IDLE, ACCESS)
  - owner encoding (OWN_I, OWN_D)
  - WSTRB_READ = 4'b0000
  - address alignment mask
- Sub-module mem_arb_priority: winner selection plus the starve counter. Inputs: Req bits and the grant event. Outputs: the winner select.

Test Plan:
- Single fetch, iwIAddr=0x10, memory ready one cycle after valid → owIGnt in cycle 0, owMemAddr=0x10 with wstrb 0 in cycle 1, owIRvalid with owIRdata=iwMemRdata (0xDEADBEEF) in cycle 2, Err=0.
- D write: addr=0x20, wstrb=4'b0011, wdata=0x11223344 → memory sees exactly these values; owDRvalid=1, Rdata=0, Err=0; no I signals toggle.
- Both requesting continuously, STARVE_LIMIT=4 → grant sequence D,D,D,D,I repeating; no I starvation.
- Misaligned D read, addr=0x22 → owDGnt, no owMemValid, owDRvalid+owDErr next cycle.
- iwMemReady held low, TIMEOUT=16 → owMemValid high exactly 16 cycles, then drops; owner gets Rvalid+Err; a following request proceeds normally.
- iwnRst pulled low mid-ACCESS → owMemValid drops asynchronously, no response pulse, and after release the first grant behaves as from reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the memory port arbiter: FSM state and owner
// encodings, the read strobe value and the word-alignment helper.
// Ports: none (package).

package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam logic [3:0]  WSTRB_READ = 4'b0000;
    localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return |(addr & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/mem_arb_priority.sv
// mem_arb_priority
// Chooses which requester wins the memory port this cycle. D normally
// wins a tie, but after STARVE_LIMIT consecutive D grants taken while I
// was waiting, I is forced through.
// Ports:
//   iwClk, iwnRst      clock, async active-low reset
//   iwIReq, iwDReq     request bits from the two requesters
//   iwGnt              a grant is being issued this cycle to the winner
//   owWinI, owWinD     winner select (at most one high)

module mem_arb_priority
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic iwClk,
    input  logic iwnRst,
    input  logic iwIReq,
    input  logic iwDReq,
    input  logic iwGnt,
    output logic owWinI,
    output logic owWinD
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q;
    logic       starved;

    assign starved = (starve_q == LIMIT);

    always_comb begin
        owWinI = 1'b0;
        owWinD = 1'b0;
        if (iwIReq && iwDReq) begin
            owWinI = starved;
            owWinD = !starved;
        end else begin
            owWinI = iwIReq;
            owWinD = iwDReq;
        end
    end

    // Only D grants taken while I is waiting count toward starvation;
    // anything else means I is not being held off.
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            starve_q <= '0;
        end else if (iwGnt) begin
            if (owWinD && iwIReq) begin
                if (!starved) begin
                    starve_q <= starve_q + 4'd1;
                end
            end else begin
                starve_q <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port byte-strobed memory between the instruction
// fetch (I) and load/store (D) requesters. Grants are combinational in
// IDLE; each aligned grant runs one valid/ready memory access, and every
// grant yields exactly one registered response pulse to its owner.
// Ports:
//   iwClk, iwnRst                      clock, async active-low reset
//   iwIReq/iwIAddr, owIGnt             fetch request / grant
//   owIRvalid/owIRdata/owIErr          fetch response
//   iwDReq/iwDAddr/iwDWstrb/iwDWdata   data request (wstrb 0 = read)
//   owDGnt, owDRvalid/owDRdata/owDErr  data grant / response
//   owMemValid/Addr/Wdata/Wstrb        memory request
//   iwMemReady/iwMemRdata              memory completion
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | no access in flight; grants issued here
// ST_ACCESS | memory access driven, waiting for ready or timeout

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic        iwClk,
    input  logic        iwnRst,
    input  logic        iwIReq,
    input  logic [31:0] iwIAddr,
    output logic        owIGnt,
    output logic        owIRvalid,
    output logic [31:0] owIRdata,
    output logic        owIErr,
    input  logic        iwDReq,
    input  logic [31:0] iwDAddr,
    input  logic [3:0]  iwDWstrb,
    input  logic [31:0] iwDWdata,
    output logic        owDGnt,
    output logic        owDRvalid,
    output logic [31:0] owDRdata,
    output logic        owDErr,
    output logic        owMemValid,
    output logic [31:0] owMemAddr,
    output logic [31:0] owMemWdata,
    output logic [3:0]  owMemWstrb,
    input  logic        iwMemReady,
    input  logic [31:0] iwMemRdata
);

    localparam int unsigned TMO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic        TMO_EN   = (TIMEOUT > 0);

    arb_state_t state_q, state_d;
    arb_owner_t owner_q;

    logic [31:0]      addr_q, wdata_q;
    logic [3:0]       wstrb_q;
    logic [TMO_W-1:0] tmo_q;

    logic        i_rvalid_q, i_err_q, d_rvalid_q, d_err_q;
    logic [31:0] i_rdata_q, d_rdata_q;

    logic        win_i, win_d;
    logic        gnt_i, gnt_d, gnt_any;
    logic        acc_start, acc_bad, acc_done, acc_abort;
    logic [31:0] sel_addr;

    logic        resp_fire, resp_err;
    arb_owner_t  resp_owner;
    logic [31:0] resp_data;

    mem_arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_priority (
        .iwClk  (iwClk),
        .iwnRst (iwnRst),
        .iwIReq (iwIReq),
        .iwDReq (iwDReq),
        .iwGnt  (gnt_any),
        .owWinI (win_i),
        .owWinD (win_d)
    );

    assign sel_addr = win_d ? iwDAddr : iwIAddr;
    assign gnt_any  = gnt_i | gnt_d;

    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grants are also gated by reset so every output is low while held.
    always_comb begin
        state_d   = state_q;
        gnt_i     = 1'b0;
        gnt_d     = 1'b0;
        acc_start = 1'b0;
        acc_bad   = 1'b0;
        acc_done  = 1'b0;
        acc_abort = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iwnRst && (win_i || win_d)) begin
                    gnt_i = win_i;
                    gnt_d = win_d;
                    if (is_misaligned(sel_addr)) begin
                        acc_bad = 1'b1;
                    end else begin
                        acc_start = 1'b1;
                        state_d   = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (iwMemReady) begin
                    acc_done = 1'b1;
                    state_d  = ST_IDLE;
                end else if (TMO_EN && (tmo_q == TMO_W'(TMO_LAST))) begin
                    acc_abort = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A misaligned grant answers in the cycle after the grant itself, so
    // its owner comes from the live grant rather than the stored owner.
    always_comb begin
        resp_fire  = acc_bad | acc_done | acc_abort;
        resp_err   = acc_bad | acc_abort;
        resp_owner = acc_bad ? (gnt_d ? OWN_D : OWN_I) : owner_q;
        resp_data  = '0;
        if (acc_done && (wstrb_q == WSTRB_READ)) begin
            resp_data = iwMemRdata;
        end
    end

    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            owner_q    <= OWN_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= WSTRB_READ;
            tmo_q      <= '0;
            i_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
            i_rdata_q  <= '0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            i_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;

            if (gnt_any) begin
                addr_q  <= sel_addr;
                owner_q <= gnt_d ? OWN_D : OWN_I;
                wdata_q <= gnt_d ? iwDWdata : '0;
                wstrb_q <= gnt_d ? iwDWstrb : WSTRB_READ;
            end

            if (acc_start) begin
                tmo_q <= '0;
            end else if ((state_q == ST_ACCESS) && !iwMemReady) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end

            if (resp_fire) begin
                if (resp_owner == OWN_D) begin
                    d_rvalid_q <= 1'b1;
                    d_err_q    <= resp_err;
                    d_rdata_q  <= resp_data;
                end else begin
                    i_rvalid_q <= 1'b1;
                    i_err_q    <= resp_err;
                    i_rdata_q  <= resp_data;
                end
            end
        end
    end

    assign owIGnt     = gnt_i;
    assign owDGnt     = gnt_d;
    assign owIRvalid  = i_rvalid_q;
    assign owIErr     = i_err_q;
    assign owIRdata   = i_rdata_q;
    assign owDRvalid  = d_rvalid_q;
    assign owDErr     = d_err_q;
    assign owDRdata   = d_rdata_q;
    assign owMemValid = (state_q == ST_ACCESS);
    assign owMemAddr  = addr_q;
    assign owMemWdata = wdata_q;
    assign owMemWstrb = wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with STARVE_LIMIT=4, TIMEOUT=16.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// on the falling edge of the same cycle.

module tb_mem_port_arbiter;

    logic        iwClk = 1'b0;
    logic        iwnRst;
    logic        iwIReq;
    logic [31:0] iwIAddr;
    logic        owIGnt;
    logic        owIRvalid;
    logic [31:0] owIRdata;
    logic        owIErr;
    logic        iwDReq;
    logic [31:0] iwDAddr;
    logic [3:0]  iwDWstrb;
    logic [31:0] iwDWdata;
    logic        owDGnt;
    logic        owDRvalid;
    logic [31:0] owDRdata;
    logic        owDErr;
    logic        owMemValid;
    logic [31:0] owMemAddr;
    logic [31:0] owMemWdata;
    logic [3:0]  owMemWstrb;
    logic        iwMemReady;
    logic [31:0] iwMemRdata;

    int checks   = 0;
    int failures = 0;

    always #5 iwClk = ~iwClk;

    mem_port_arbiter #(
        .STARVE_LIMIT (4),
        .TIMEOUT      (16)
    ) dut (
        .iwClk      (iwClk),
        .iwnRst     (iwnRst),
        .iwIReq     (iwIReq),
        .iwIAddr    (iwIAddr),
        .owIGnt     (owIGnt),
        .owIRvalid  (owIRvalid),
        .owIRdata   (owIRdata),
        .owIErr     (owIErr),
        .iwDReq     (iwDReq),
        .iwDAddr    (iwDAddr),
        .iwDWstrb   (iwDWstrb),
        .iwDWdata   (iwDWdata),
        .owDGnt     (owDGnt),
        .owDRvalid  (owDRvalid),
        .owDRdata   (owDRdata),
        .owDErr     (owDErr),
        .owMemValid (owMemValid),
        .owMemAddr  (owMemAddr),
        .owMemWdata (owMemWdata),
        .owMemWstrb (owMemWstrb),
        .iwMemReady (iwMemReady),
        .iwMemRdata (iwMemRdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge iwClk);
        #1;
    endtask

    // One aligned access with memory ready in the first ACCESS cycle.
    task automatic run_access(input string tag, input bit is_d,
                              input logic [31:0] addr, input logic [3:0] strb,
                              input logic [31:0] wdata, input logic [31:0] mrdata);
        logic [31:0] exp_rdata;
        exp_rdata = (is_d && strb != 4'b0000) ? 32'h0 : mrdata;

        next_cycle();
        if (is_d) begin
            iwDReq = 1'b1; iwDAddr = addr; iwDWstrb = strb; iwDWdata = wdata;
        end else begin
            iwIReq = 1'b1; iwIAddr = addr;
        end
        @(negedge iwClk);
        chk({tag, "_ignt"}, 32'(owIGnt), 32'(!is_d));
        chk({tag, "_dgnt"}, 32'(owDGnt), 32'(is_d));
        chk({tag, "_valid0"}, 32'(owMemValid), 32'd0);

        next_cycle();
        iwIReq = 1'b0; iwDReq = 1'b0;
        iwDWstrb = 4'h0; iwDWdata = 32'h0;
        iwMemReady = 1'b1; iwMemRdata = mrdata;
        @(negedge iwClk);
        chk({tag, "_valid1"}, 32'(owMemValid), 32'd1);
        chk({tag, "_maddr"}, owMemAddr, addr);
        chk({tag, "_mstrb"}, 32'(owMemWstrb), is_d ? 32'(strb) : 32'd0);
        chk({tag, "_mwdata"}, owMemWdata, is_d ? wdata : 32'h0);

        next_cycle();
        iwMemReady = 1'b0; iwMemRdata = 32'h0;
        @(negedge iwClk);
        chk({tag, "_valid2"}, 32'(owMemValid), 32'd0);
        chk({tag, "_rvalid"}, 32'(is_d ? owDRvalid : owIRvalid), 32'd1);
        chk({tag, "_other_rvalid"}, 32'(is_d ? owIRvalid : owDRvalid), 32'd0);
        chk({tag, "_err"}, 32'(is_d ? owDErr : owIErr), 32'd0);
        chk({tag, "_rdata"}, is_d ? owDRdata : owIRdata, exp_rdata);
    endtask

    logic     exp_seq [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int       n_gnt;
    int       n_valid;

    initial begin
        iwnRst = 1'b0;
        iwIReq = 1'b0; iwIAddr = 32'h0;
        iwDReq = 1'b0; iwDAddr = 32'h0; iwDWstrb = 4'h0; iwDWdata = 32'h0;
        iwMemReady = 1'b0; iwMemRdata = 32'h0;

        repeat (3) @(posedge iwClk);
        @(negedge iwClk);
        chk("rst_valid", 32'(owMemValid), 32'd0);
        chk("rst_irvalid", 32'(owIRvalid), 32'd0);
        chk("rst_drdata", owDRdata, 32'h0);
        next_cycle();
        iwnRst = 1'b1;

        // Single fetch, then a D write that must not disturb I outputs.
        run_access("fetch", 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEAD_BEEF);
        next_cycle();
        @(negedge iwClk);
        chk("fetch_pulse", 32'(owIRvalid), 32'd0);
        chk("fetch_hold", owIRdata, 32'hDEAD_BEEF);

        run_access("dwr", 1'b1, 32'h20, 4'b0011, 32'h1122_3344, 32'hCAFE_F00D);
        chk("dwr_ihold", owIRdata, 32'hDEAD_BEEF);

        // Both requesting continuously, memory always ready.
        next_cycle();
        iwIReq = 1'b1; iwIAddr = 32'h40;
        iwDReq = 1'b1; iwDAddr = 32'h80; iwDWstrb = 4'h0;
        iwMemReady = 1'b1; iwMemRdata = 32'h5A5A_5A5A;
        n_gnt = 0;
        for (int c = 0; c < 40 && n_gnt < 10; c++) begin
            @(negedge iwClk);
            if (owIGnt || owDGnt) begin
                chk("arb_onehot", 32'(owIGnt & owDGnt), 32'd0);
                chk($sformatf("arb_seq%0d", n_gnt), 32'(owDGnt), 32'(exp_seq[n_gnt]));
                n_gnt++;
            end
            next_cycle();
        end
        chk("arb_count", 32'(n_gnt), 32'd10);
        iwIReq = 1'b0; iwDReq = 1'b0;
        next_cycle();
        iwMemReady = 1'b0; iwMemRdata = 32'h0;
        @(negedge iwClk);
        chk("arb_drdata", owDRdata, 32'h5A5A_5A5A);

        // Misaligned D read: granted, no memory cycle, error next cycle.
        next_cycle();
        iwDReq = 1'b1; iwDAddr = 32'h22; iwDWstrb = 4'h0;
        @(negedge iwClk);
        chk("mis_dgnt", 32'(owDGnt), 32'd1);
        next_cycle();
        iwDReq = 1'b0;
        @(negedge iwClk);
        chk("mis_valid", 32'(owMemValid), 32'd0);
        chk("mis_rvalid", 32'(owDRvalid), 32'd1);
        chk("mis_err", 32'(owDErr), 32'd1);
        chk("mis_rdata", owDRdata, 32'h0);
        next_cycle();
        @(negedge iwClk);
        chk("mis_valid_after", 32'(owMemValid), 32'd0);
        chk("mis_pulse", 32'(owDRvalid), 32'd0);

        // Timeout with ready held low.
        next_cycle();
        iwIReq = 1'b1; iwIAddr = 32'h30;
        @(negedge iwClk);
        chk("tmo_ignt", 32'(owIGnt), 32'd1);
        next_cycle();
        iwIReq = 1'b0;
        n_valid = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge iwClk);
            if (!owMemValid) break;
            n_valid++;
            next_cycle();
        end
        chk("tmo_len", 32'(n_valid), 32'd16);
        chk("tmo_rvalid", 32'(owIRvalid), 32'd1);
        chk("tmo_err", 32'(owIErr), 32'd1);
        chk("tmo_rdata", owIRdata, 32'h0);
        run_access("post_tmo", 1'b1, 32'h44, 4'h0, 32'h0, 32'h0BAD_F00D);

        // Reset asserted in the middle of an access.
        next_cycle();
        iwIReq = 1'b1; iwIAddr = 32'h50;
        next_cycle();
        iwIReq = 1'b0;
        @(negedge iwClk);
        chk("rstmid_valid1", 32'(owMemValid), 32'd1);
        #2;
        iwnRst = 1'b0;
        #1;
        chk("rstmid_async", 32'(owMemValid), 32'd0);
        next_cycle();
        iwnRst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge iwClk);
            chk("rstmid_no_irvalid", 32'(owIRvalid), 32'd0);
            chk("rstmid_no_valid", 32'(owMemValid), 32'd0);
            next_cycle();
        end
        chk("rstmid_irdata", owIRdata, 32'h0);
        iwIReq = 1'b1; iwIAddr = 32'h60;
        iwDReq = 1'b1; iwDAddr = 32'h64; iwDWstrb = 4'h0;
        @(negedge iwClk);
        chk("rstmid_dgnt", 32'(owDGnt), 32'd1);
        chk("rstmid_ignt", 32'(owIGnt), 32'd0);
        next_cycle();
        iwIReq = 1'b0; iwDReq = 1'b0;
        iwMemReady = 1'b1; iwMemRdata = 32'h1234_5678;
        @(negedge iwClk);
        chk("rstmid_maddr", owMemAddr, 32'h64);
        next_cycle();
        iwMemReady = 1'b0;
        @(negedge iwClk);
        chk("rstmid_drvalid", 32'(owDRvalid), 32'd1);
        chk("rstmid_drdata", owDRdata, 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
